// File: rtl/usb_utmi_rx_pkt.sv
// usb_utmi_rx_pkt: UTMI receive packet decoder with PID classing, CRC5/CRC16 checks and CRC-stripped payload stream.
module usb_utmi_rx_pkt #(
    parameter int MAX_PAYLOAD = 1024
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] utmi_data_in_i,
    input  logic       utmi_rxvalid_i,
    input  logic       utmi_rxactive_i,
    input  logic       utmi_rxerror_i,
    output logic [3:0] pid_o,
    output logic       token_valid_o,
    output logic [6:0] token_addr_o,
    output logic [3:0] token_ep_o,
    output logic [7:0] data_o,
    output logic       data_valid_o,
    output logic       pkt_end_o,
    output logic       pkt_ok_o,
    output logic [2:0] err_o
);
    localparam int CW = $clog2(MAX_PAYLOAD + 3);
    localparam logic [CW-1:0] LIM = CW'(MAX_PAYLOAD + 2);
    localparam logic [CW-1:0] TWO = CW'(2);
    localparam logic [CW-1:0] ONE = CW'(1);

    typedef enum logic [2:0] {IDLE, PID, TOKEN, DATA, HSK, DISCARD} state_t;

    state_t        state, state_nxt;
    logic          armed;
    logic [2:0]    err, err_set, err_fin;
    logic [CW-1:0] cnt;
    logic [4:0]    crc5;
    logic [15:0]   crc16;
    logic [10:0]   tok;
    logic [7:0]    dly0, dly1, b;
    logic          act, acc, take, start, in_pid, eop, abort, bad_len, emit;
    logic          pid_ok, is_tok, is_dat, is_hsk;

    function automatic logic [4:0] f5(input logic [4:0] c, input logic [7:0] d);
        logic [4:0] r;
        r = c;
        for (int i = 0; i < 8; i++) r = {r[3:0], 1'b0} ^ ((r[4] ^ d[i]) ? 5'h05 : 5'h00);
        return r;
    endfunction

    function automatic logic [15:0] f16(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++) r = {r[14:0], 1'b0} ^ ((r[15] ^ d[i]) ? 16'h8005 : 16'h0000);
        return r;
    endfunction

    assign b       = utmi_data_in_i;
    assign act     = utmi_rxactive_i;
    assign acc     = act && utmi_rxvalid_i;
    assign take    = acc && !utmi_rxerror_i;
    // the PID byte may already arrive in the cycle rxactive rises
    assign start   = state == IDLE && act && armed;
    assign in_pid  = state == PID || start;
    assign eop     = state != IDLE && !act;
    assign abort   = act && utmi_rxerror_i && (state != IDLE || start);
    assign pid_ok  = b[7:4] == ~b[3:0];
    assign is_tok  = b[1:0] == 2'b01 || b[3:0] == 4'b0100;
    assign is_dat  = b[1:0] == 2'b11;
    assign is_hsk  = b[1:0] == 2'b10;
    assign bad_len = acc && (state == HSK || (state == TOKEN && cnt == TWO) || (state == DATA && cnt == LIM));

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state <= IDLE;
            armed <= 1'b0;
        end else begin
            state <= state_nxt;
            armed <= armed || !act;
        end
    end

    always_comb begin
        state_nxt = state;
        if (eop) state_nxt = IDLE;
        else if (abort) state_nxt = DISCARD;
        else if (in_pid && acc) state_nxt = !pid_ok ? DISCARD : is_tok ? TOKEN : is_dat ? DATA : is_hsk ? HSK : DISCARD;
        else if (start) state_nxt = PID;
        else if (bad_len) state_nxt = DISCARD;
    end

    always_comb begin
        err_set = abort ? 3'd4
                : (in_pid && acc) ? (!pid_ok ? 3'd1 : (is_tok || is_dat || is_hsk) ? 3'd0 : 3'd5)
                : bad_len ? 3'd3 : err;
        err_fin = err != 3'd0 ? err
                : state == PID ? 3'd3
                : state == TOKEN ? (cnt != TWO ? 3'd3 : crc5 != 5'b01100 ? 3'd2 : 3'd0)
                : state == DATA ? (cnt < TWO ? 3'd3 : crc16 != 16'h800D ? 3'd2 : 3'd0)
                : 3'd0;
        emit = take && state == DATA && cnt >= TWO && cnt != LIM;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            err           <= '0;
            cnt           <= '0;
            crc5          <= '0;
            crc16         <= '0;
            tok           <= '0;
            dly0          <= '0;
            dly1          <= '0;
            pid_o         <= '0;
            token_valid_o <= 1'b0;
            token_addr_o  <= '0;
            token_ep_o    <= '0;
            data_o        <= '0;
            data_valid_o  <= 1'b0;
            pkt_end_o     <= 1'b0;
            pkt_ok_o      <= 1'b0;
            err_o         <= '0;
        end else begin
            err           <= eop ? 3'd0 : err_set;
            data_valid_o  <= emit;
            pkt_end_o     <= eop;
            token_valid_o <= 1'b0;
            if (in_pid && take) begin
                cnt   <= '0;
                crc5  <= 5'h1F;
                crc16 <= 16'hFFFF;
                if (pid_ok) pid_o <= b[3:0];
            end
            if (take && state == TOKEN && cnt != TWO) begin
                cnt  <= cnt + ONE;
                crc5 <= f5(crc5, b);
                if (cnt == '0) tok[7:0] <= b;
                else tok[10:8] <= b[2:0];
            end
            // two-byte delay line holds back what may turn out to be the CRC16
            if (take && state == DATA && cnt != LIM) begin
                cnt   <= cnt + ONE;
                crc16 <= f16(crc16, b);
                dly0  <= b;
                dly1  <= dly0;
            end
            if (emit) data_o <= dly1;
            if (eop) begin
                pkt_ok_o <= err_fin == 3'd0;
                err_o    <= err_fin;
                if (state == TOKEN && err_fin == 3'd0) begin
                    token_valid_o <= 1'b1;
                    token_addr_o  <= tok[6:0];
                    token_ep_o    <= tok[10:7];
                end
            end
        end
    end
endmodule

// File: tb/tb_usb_utmi_rx_pkt.sv
// tb_usb_utmi_rx_pkt: table, directed and randomized checks of usb_utmi_rx_pkt against a packet-level model.
module tb_usb_utmi_rx_pkt;
    localparam int MAXP = 1024;

    logic       clk = 1'b0, rst = 1'b0;
    logic [7:0] din = '0;
    logic       vld = 1'b0, act = 1'b0, rxerr = 1'b0;
    logic [3:0] pid, ep;
    logic [6:0] addr;
    logic [7:0] dout;
    logic       tv, dv, pend, pok;
    logic [2:0] err;

    always #5 clk = ~clk;

    usb_utmi_rx_pkt #(.MAX_PAYLOAD(MAXP)) dut (
        .clk_i(clk), .rst_i(rst),
        .utmi_data_in_i(din), .utmi_rxvalid_i(vld), .utmi_rxactive_i(act), .utmi_rxerror_i(rxerr),
        .pid_o(pid), .token_valid_o(tv), .token_addr_o(addr), .token_ep_o(ep),
        .data_o(dout), .data_valid_o(dv), .pkt_end_o(pend), .pkt_ok_o(pok), .err_o(err)
    );

    typedef struct {
        string      nm;
        int         len;
        logic [7:0] b [4];
        logic       ok;
        logic [2:0] e;
        logic       tk;
        logic [3:0] p;
    } vec_t;

    vec_t        tbl [11];
    logic [7:0]  tx[$], got_d[$], m_data[$];
    logic [15:0] got_end[$];
    int          n_cmp = 0, n_bad = 0, stray = 0;
    logic        m_ok, m_tok;
    logic [2:0]  m_err;
    logic [3:0]  m_pid = '0, m_ep = '0;
    logic [6:0]  m_addr = '0;

    always @(negedge clk) begin
        if (dv) got_d.push_back(dout);
        if (pend) got_end.push_back({pok, err, tv, addr, ep});
        else if (tv) stray++;
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic logic [4:0] crc5_ref(input logic [10:0] f);
        logic [4:0] r;
        r = 5'h1F;
        for (int i = 0; i < 11; i++) r = (r[0] ^ f[i]) ? (r >> 1) ^ 5'h14 : r >> 1;
        return ~r;
    endfunction

    function automatic logic [15:0] crc16_ref(input int lo, input int hi);
        logic [15:0] r;
        r = 16'hFFFF;
        for (int i = lo; i <= hi; i++)
            for (int k = 0; k < 8; k++) r = (r[0] ^ tx[i][k]) ? (r >> 1) ^ 16'hA001 : r >> 1;
        return ~r;
    endfunction

    // packet-level expectation for the bytes in tx; ep_ is the index of the byte carrying rxerror, or -1
    task automatic predict(input int ep_);
        logic [7:0] p;
        logic       good;
        int         n;
        m_data.delete();
        m_tok = 1'b0;
        n     = tx.size();
        p     = tx[0];
        good  = ep_ != 0 && p[7:4] == ~p[3:0];
        if (good) m_pid = p[3:0];
        if (ep_ >= 0) begin
            m_err = 3'd4;
            if (good && p[3:0] inside {4'h3, 4'hB, 4'h7, 4'hF})
                for (int i = 1; i <= ep_ - 3; i++) m_data.push_back(tx[i]);
        end else if (!good) m_err = 3'd1;
        else if (p[3:0] inside {4'h1, 4'h9, 4'hD, 4'h5, 4'h4}) begin
            if (n != 3) m_err = 3'd3;
            else if (crc5_ref({tx[2][2:0], tx[1]}) != tx[2][7:3]) m_err = 3'd2;
            else begin
                m_err  = 3'd0;
                m_tok  = 1'b1;
                m_addr = tx[1][6:0];
                m_ep   = {tx[2][2:0], tx[1][7]};
            end
        end else if (p[3:0] inside {4'h3, 4'hB, 4'h7, 4'hF}) begin
            if (n < 3) m_err = 3'd3;
            else if (n - 3 > MAXP) begin
                m_err = 3'd3;
                for (int i = 1; i <= MAXP; i++) m_data.push_back(tx[i]);
            end else begin
                for (int i = 1; i <= n - 3; i++) m_data.push_back(tx[i]);
                m_err = crc16_ref(1, n - 3) == {tx[n-1], tx[n-2]} ? 3'd0 : 3'd2;
            end
        end else if (p[3:0] inside {4'h2, 4'hA, 4'hE, 4'h6}) m_err = n == 1 ? 3'd0 : 3'd3;
        else m_err = 3'd5;
        m_ok = m_err == 3'd0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int gap, input int ep_);
        act = 1'b1;
        step();
        for (int i = 0; i < tx.size(); i++) begin
            for (int g = 0; g < 6 && gap > 0 && $urandom_range(99) < gap; g++) step();
            din   = tx[i];
            vld   = 1'b1;
            rxerr = i == ep_;
            step();
            vld   = 1'b0;
            rxerr = 1'b0;
            din   = 8'($urandom);
        end
        act = 1'b0;
        step();
    endtask

    task automatic check_pkt(input string nm);
        int bi;
        chk({nm, " ends"}, got_end.size(), 1);
        if (got_end.size() == 1) begin
            chk({nm, " ok"}, got_end[0][15], m_ok);
            chk({nm, " err"}, got_end[0][14:12], m_err);
            chk({nm, " token_valid"}, got_end[0][11], m_tok);
        end
        chk({nm, " pid"}, pid, m_pid);
        chk({nm, " addr/ep"}, {addr, ep}, {m_addr, m_ep});
        chk({nm, " nbytes"}, got_d.size(), m_data.size());
        bi = -1;
        for (int i = 0; i < got_d.size() && i < m_data.size(); i++)
            if (bi < 0 && got_d[i] !== m_data[i]) bi = i;
        if (m_data.size() > 0) begin
            n_cmp++;
            if (bi >= 0) begin
                n_bad++;
                $display("FAIL %s data[%0d]: got %02h expected %02h", nm, bi, got_d[bi], m_data[bi]);
            end
        end
    endtask

    task automatic run(input string nm, input int gap, input int ep_);
        got_d.delete();
        got_end.delete();
        predict(ep_);
        send(gap, ep_);
        step();
        check_pkt(nm);
    endtask

    task automatic mk_tok(input logic [7:0] p, input logic [10:0] f);
        tx = '{p, f[7:0], {crc5_ref(f), f[10:8]}};
    endtask

    task automatic mk_data(input logic [7:0] p, input int n);
        logic [15:0] c;
        tx = '{p};
        for (int i = 0; i < n; i++) tx.push_back(8'($urandom));
        c = crc16_ref(1, n);
        tx.push_back(c[7:0]);
        tx.push_back(c[15:8]);
    endtask

    task automatic add(input int i, input string nm, input int len, input logic [31:0] bs,
                       input logic ok, input logic [2:0] e, input logic tk, input logic [3:0] p);
        tbl[i].nm = nm;
        tbl[i].len = len;
        for (int j = 0; j < 4; j++) tbl[i].b[j] = bs[31-8*j -: 8];
        tbl[i].ok = ok;
        tbl[i].e  = e;
        tbl[i].tk = tk;
        tbl[i].p  = p;
    endtask

    logic [15:0] e1;
    logic [7:0]  toks[5] = '{8'hE1, 8'h69, 8'h2D, 8'hA5, 8'hB4};
    logic [7:0]  dats[4] = '{8'hC3, 8'h4B, 8'h87, 8'h0F};
    logic [7:0]  hsks[4] = '{8'hD2, 8'h5A, 8'h1E, 8'h96};

    initial begin
        add(0,  "setup",      3, 32'h2D001000, 1, 0, 1, 4'hD);
        add(1,  "setup crc",  3, 32'h2D001100, 0, 2, 0, 4'hD);
        add(2,  "zlp data0",  3, 32'hC3000000, 1, 0, 0, 4'h3);
        add(3,  "ack",        1, 32'hD2000000, 1, 0, 0, 4'h2);
        add(4,  "bad pid",    1, 32'hD3000000, 0, 1, 0, 4'h2);
        add(5,  "split",      1, 32'h78000000, 0, 5, 0, 4'h8);
        add(6,  "ack extra",  2, 32'hD2550000, 0, 3, 0, 4'h2);
        add(7,  "token long", 4, 32'h2D001000, 0, 3, 0, 4'hD);
        add(8,  "token short",2, 32'hE1000000, 0, 3, 0, 4'h1);
        add(9,  "data short", 2, 32'h4B000000, 0, 3, 0, 4'hB);
        add(10, "in",         3, 32'h69001000, 1, 0, 1, 4'h9);

        repeat (3) step();
        chk("reset outputs", {pid, tv, addr, ep, dout, dv, pend, pok, err}, 0);
        rst = 1'b1;
        repeat (2) step();

        foreach (tbl[i]) begin
            tx.delete();
            for (int j = 0; j < tbl[i].len; j++) tx.push_back(tbl[i].b[j]);
            got_d.delete();
            got_end.delete();
            predict(-1);
            send(0, -1);
            step();
            chk({tbl[i].nm, " ends"}, got_end.size(), 1);
            if (got_end.size() == 1) begin
                chk({tbl[i].nm, " ok"}, got_end[0][15], tbl[i].ok);
                chk({tbl[i].nm, " err"}, got_end[0][14:12], tbl[i].e);
                chk({tbl[i].nm, " token_valid"}, got_end[0][11], tbl[i].tk);
            end
            chk({tbl[i].nm, " pid"}, pid, tbl[i].p);
            chk({tbl[i].nm, " nbytes"}, got_d.size(), 0);
        end

        mk_data(8'h4B, 8);
        run("data1 x8", 0, -1);
        run("data1 x8 gaps", 40, -1);
        mk_data(8'hC3, 10);
        run("rxerror", 0, 5);
        mk_data(8'h4B, MAXP + 1);
        run("overflow", 0, -1);

        got_d.delete();
        got_end.delete();
        mk_tok(8'h69, 11'h2A5);
        predict(-1);
        e1 = {m_ok, m_err, m_tok, m_addr, m_ep};
        send(0, -1);
        mk_tok(8'hE1, 11'h713);
        predict(-1);
        send(0, -1);
        step();
        chk("b2b ends", got_end.size(), 2);
        if (got_end.size() == 2) begin
            chk("b2b first", got_end[0], e1);
            chk("b2b second", got_end[1], {m_ok, m_err, m_tok, m_addr, m_ep});
        end
        chk("b2b addr/ep", {addr, ep}, {m_addr, m_ep});

        got_end.delete();
        mk_data(8'hC3, 6);
        act = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            din = tx[i];
            vld = 1'b1;
            step();
            vld = 1'b0;
        end
        rst = 1'b0;
        step();
        chk("reset mid outputs", {pid, tv, addr, ep, dout, dv, pend, pok, err}, 0);
        rst = 1'b1;
        for (int i = 5; i < tx.size(); i++) begin
            din = tx[i];
            vld = 1'b1;
            step();
            vld = 1'b0;
        end
        act = 1'b0;
        repeat (3) step();
        chk("reset no end", got_end.size(), 0);
        m_pid  = '0;
        m_addr = '0;
        m_ep   = '0;
        tx = '{8'h2D, 8'h00, 8'h10};
        run("setup after reset", 0, -1);

        for (int k = 0; k < 80; k++) begin
            int kind, gap, ep_;
            kind = $urandom_range(4);
            gap  = $urandom_range(1) ? 30 : 0;
            ep_  = -1;
            case (kind)
                0, 1: begin
                    mk_tok(toks[$urandom_range(4)], 11'($urandom));
                    if (kind == 1) tx[$urandom_range(2, 1)][$urandom_range(7)] ^= 1'b1;
                end
                2: begin
                    mk_data(dats[$urandom_range(3)], $urandom_range(24));
                    if ($urandom_range(3) == 0) tx[$urandom_range(tx.size() - 1, 1)][$urandom_range(7)] ^= 1'b1;
                    else if ($urandom_range(4) == 0) ep_ = $urandom_range(tx.size() - 1, 1);
                end
                3: begin
                    tx = '{hsks[$urandom_range(3)]};
                    if ($urandom_range(4) == 0) tx.push_back(8'($urandom));
                end
                default: begin
                    tx = '{8'($urandom)};
                    repeat ($urandom_range(2)) tx.push_back(8'($urandom));
                end
            endcase
            run($sformatf("rand%0d", k), gap, ep_);
        end

        chk("stray token_valid", stray, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
